// File: rtl/mac_pkg.sv
// Shared constants and helpers for the lane multiply-accumulate datapath.
package mac_pkg;

   localparam int default_bw      = 4;
   localparam int default_psum_bw = 16;
   localparam int default_lanes   = 4;

   // A bw x bw product with one operand possibly zero-extended needs one extra bit.
   function automatic int prod_width(input int bw);
      return 2 * bw + 1;
   endfunction

endpackage

// File: rtl/mac_lane_acc_if.sv
// Beat, weight-load and result signals shared between the accumulator and its driver.
interface mac_lane_acc_if
   import mac_pkg::*;
#(
   parameter int bw      = default_bw,
   parameter int psum_bw = default_psum_bw,
   parameter int lanes   = default_lanes
);

   logic                      w_load;
   logic [lanes*bw-1:0]       w_in;
   logic                      in_valid;
   logic [lanes*bw-1:0]       a_in;
   logic                      acc_clr;
   logic signed [psum_bw-1:0] out;
   logic                      out_valid;
   logic                      ovf;

   modport master (
      output w_load, w_in, in_valid, a_in, acc_clr,
      input  out, out_valid, ovf
   );

   modport slave (
      input  w_load, w_in, in_valid, a_in, acc_clr,
      output out, out_valid, ovf
   );

endinterface

// File: rtl/mac_mul.sv
// Combinational single-lane multiplier: signed weight times activation of selectable signedness.
module mac_mul
   import mac_pkg::*;
#(
   parameter int bw         = default_bw,
   parameter bit act_signed = 1'b0
) (
   input  logic        [bw-1:0]             a,
   input  logic signed [bw-1:0]             b,
   output logic signed [prod_width(bw)-1:0] p
);

   localparam int pw = prod_width(bw);

   logic signed [bw:0]   a_ext;
   logic signed [pw-1:0] a_w;
   logic signed [pw-1:0] b_w;

   // Widen both operands to the full product width first so the multiply is exact.
   assign a_ext = act_signed ? $signed({a[bw-1], a}) : $signed({1'b0, a});
   assign a_w   = {{bw{a_ext[bw]}}, a_ext};
   assign b_w   = {{(bw+1){b[bw-1]}}, b};
   assign p     = a_w * b_w;

endmodule

// File: rtl/mac_lane_acc.sv
// Two-stage lane dot-product accumulator: products registered, then summed into a wrapping accumulator.
module mac_lane_acc
   import mac_pkg::*;
#(
   parameter int bw         = default_bw,
   parameter int psum_bw    = default_psum_bw,
   parameter int lanes      = default_lanes,
   parameter bit act_signed = 1'b0
) (
   input logic           clk,
   input logic           reset_n,
   mac_lane_acc_if.slave bus
);

   localparam int pw = prod_width(bw);

   // The lane sum can never overflow inside the tree for legal parameters.
   if (longint'(lanes) * (longint'(1) << (2 * bw)) > (longint'(1) << (psum_bw - 1))) begin : g_width_check
      $error("mac_lane_acc: psum_bw too narrow for lanes*2^(2*bw)");
   end

   logic [lanes*bw-1:0]       w_q;
   logic signed [pw-1:0]      prod_c [lanes];
   logic signed [pw-1:0]      prod_q [lanes];
   logic                      s1_valid;
   logic                      s1_clr;
   logic signed [psum_bw-1:0] lane_sum;
   logic signed [psum_bw-1:0] acc_q;
   logic signed [psum_bw-1:0] acc_base;
   logic signed [psum_bw-1:0] acc_sum;
   logic                      add_ovf;
   logic                      out_valid_q;
   logic                      ovf_q;

   for (genvar k = 0; k < lanes; k++) begin : g_lane
      mac_mul #(
         .bw        (bw),
         .act_signed(act_signed)
      ) u_mul (
         .a(bus.a_in[k*bw +: bw]),
         .b(w_q[k*bw +: bw]),
         .p(prod_c[k])
      );
   end

   // Stage 1 reads the weight register before any same-edge load takes effect.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         w_q      <= '0;
         s1_valid <= 1'b0;
         s1_clr   <= 1'b0;
         for (int i = 0; i < lanes; i++) prod_q[i] <= '0;
      end else begin
         if (bus.w_load) w_q <= bus.w_in;
         s1_valid <= bus.in_valid;
         s1_clr   <= bus.acc_clr;
         if (bus.in_valid) begin
            for (int i = 0; i < lanes; i++) prod_q[i] <= prod_c[i];
         end
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < lanes; i++) begin
         lane_sum = lane_sum + {{(psum_bw-pw){prod_q[i][pw-1]}}, prod_q[i]};
      end
   end

   // A clear discards the old accumulator, so the add starts from zero and cannot overflow.
   always_comb begin
      acc_base = s1_clr ? '0 : acc_q;
      acc_sum  = acc_base + lane_sum;
      add_ovf  = (acc_base[psum_bw-1] == lane_sum[psum_bw-1]) &&
                 (acc_sum[psum_bw-1] != acc_base[psum_bw-1]);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            acc_q <= acc_sum;
            ovf_q <= (ovf_q & ~s1_clr) | add_ovf;
         end else if (s1_clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.out       = acc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_lane_acc.sv
// Randomized and directed bench for mac_lane_acc against a beat-level arithmetic model.
module tb_mac_lane_acc;
   import mac_pkg::*;

   localparam int bw      = default_bw;
   localparam int psum_bw = default_psum_bw;
   localparam int lanes   = default_lanes;
   localparam int vw      = lanes * bw;
   localparam longint pmax = (longint'(1) << (psum_bw - 1)) - 1;
   localparam longint pmin = -(longint'(1) << (psum_bw - 1));

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mac_lane_acc_if #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes)) ifc ();
   mac_lane_acc_if #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes)) ifs ();

   mac_lane_acc #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes), .act_signed(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(ifc)
   );

   mac_lane_acc #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes), .act_signed(1'b1)) dut_s (
      .clk(clk), .reset_n(reset_n), .bus(ifs)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   typedef struct {
      int     due;
      bit     valid;
      bit     clr;
      longint sum;
   } ev_t;

   ev_t    evq[$];
   int     m_w[lanes];
   longint m_acc = 0;
   bit     m_ovf = 1'b0;
   bit     m_ovalid = 1'b0;
   int     cyc = 0;

   function automatic int lane_w(input logic [vw-1:0] v, input int k);
      int x;
      x = int'((v >> (k * bw)) & ((1 << bw) - 1));
      if (x >= (1 << (bw - 1))) x = x - (1 << bw);
      return x;
   endfunction

   function automatic int lane_a(input logic [vw-1:0] v, input int k);
      return int'((v >> (k * bw)) & ((1 << bw) - 1));
   endfunction

   function automatic longint wrap(input longint t);
      longint r;
      r = t & ((longint'(1) << psum_bw) - 1);
      if (r > pmax) r = r - (longint'(1) << psum_bw);
      return r;
   endfunction

   // Each accepted beat is a dot product that lands on the accumulator one edge later.
   always @(posedge clk) begin
      ev_t    e;
      longint t;
      longint s;
      cyc++;
      m_ovalid = 1'b0;
      if (!reset_n) begin
         evq.delete();
         for (int k = 0; k < lanes; k++) m_w[k] = 0;
         m_acc = 0;
         m_ovf = 1'b0;
      end else begin
         if (evq.size() > 0 && evq[0].due == cyc) begin
            e = evq.pop_front();
            if (e.clr) begin
               m_acc = 0;
               m_ovf = 1'b0;
            end
            if (e.valid) begin
               t = m_acc + e.sum;
               if (t > pmax || t < pmin) m_ovf = 1'b1;
               m_acc = wrap(t);
               m_ovalid = 1'b1;
            end
         end
         if (ifc.in_valid || ifc.acc_clr) begin
            s = 0;
            if (ifc.in_valid) begin
               for (int k = 0; k < lanes; k++) s += longint'(lane_a(ifc.a_in, k) * m_w[k]);
            end
            evq.push_back('{due: cyc + 1, valid: ifc.in_valid, clr: ifc.acc_clr, sum: s});
         end
         if (ifc.w_load) begin
            for (int k = 0; k < lanes; k++) m_w[k] = lane_w(ifc.w_in, k);
         end
      end
   end

   task automatic checkOutput(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Continuous comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("model_out", longint'($signed(ifc.out)), m_acc);
         checkOutput("model_out_valid", longint'(ifc.out_valid), longint'(m_ovalid));
         checkOutput("model_ovf", longint'(ifc.ovf), longint'(m_ovf));
      end
   end

   task automatic applyStimulus(input bit wl, input logic [vw-1:0] w, input bit v,
                                input logic [vw-1:0] a, input bit clr);
      ifc.w_load   = wl;
      ifc.w_in     = w;
      ifc.in_valid = v;
      ifc.a_in     = a;
      ifc.acc_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   function automatic longint outNow();
      return longint'($signed(ifc.out));
   endfunction

   initial begin
      ifs.w_load = 1'b0; ifs.w_in = '0; ifs.in_valid = 1'b0; ifs.a_in = '0; ifs.acc_clr = 1'b0;
      reset_n = 1'b0;
      idle(2);
      chk_en  = 1'b1;
      reset_n = 1'b1;
      checkOutput("reset_out", outNow(), 0);
      checkOutput("reset_out_valid", longint'(ifc.out_valid), 0);
      checkOutput("reset_ovf", longint'(ifc.ovf), 0);

      // Weights {1,2,3,4}, three beats of ones.
      applyStimulus(1'b1, 16'h4321, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 16'h1111, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 16'h1111, 1'b0);
      checkOutput("basic_beat1", outNow(), 10);
      checkOutput("basic_valid1", longint'(ifc.out_valid), 1);
      applyStimulus(1'b0, '0, 1'b1, 16'h1111, 1'b0);
      checkOutput("basic_beat2", outNow(), 20);
      idle(1);
      checkOutput("basic_beat3", outNow(), 30);
      idle(1);
      checkOutput("basic_hold", outNow(), 30);
      checkOutput("basic_valid_drop", longint'(ifc.out_valid), 0);

      // Weight load on the same edge as a beat.
      applyStimulus(1'b1, 16'h1111, 1'b0, '0, 1'b1);
      applyStimulus(1'b1, 16'h2222, 1'b1, 16'h1111, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 16'h1111, 1'b0);
      checkOutput("wload_old_weights", outNow(), 4);
      idle(1);
      checkOutput("wload_new_weights", outNow(), 12);

      // Weights -8, activations 15: drive into signed overflow.
      applyStimulus(1'b1, 16'h8888, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 16'hFFFF, 1'b1);
      idle(1);
      checkOutput("neg_first", outNow(), -480);
      checkOutput("neg_first_ovf", longint'(ifc.ovf), 0);
      repeat (68) applyStimulus(1'b0, '0, 1'b1, 16'hFFFF, 1'b0);
      idle(1);
      checkOutput("ovf_wrapped", outNow(), 32416);
      checkOutput("ovf_set", longint'(ifc.ovf), 1);
      idle(1);
      checkOutput("ovf_sticky", longint'(ifc.ovf), 1);

      // Clear with no beat.
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      idle(1);
      checkOutput("clr_alone_out", outNow(), 0);
      checkOutput("clr_alone_ovf", longint'(ifc.ovf), 0);
      checkOutput("clr_alone_valid", longint'(ifc.out_valid), 0);

      // Overflow again, then reset while a beat is in flight.
      applyStimulus(1'b0, '0, 1'b1, 16'hFFFF, 1'b1);
      repeat (68) applyStimulus(1'b0, '0, 1'b1, 16'hFFFF, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 16'hFFFF, 1'b0);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("reset_drop_valid", longint'(ifc.out_valid), 0);
         idle(1);
      end
      checkOutput("reset_drop_out", outNow(), 0);
      checkOutput("reset_drop_ovf", longint'(ifc.ovf), 0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 199) != 0);
         applyStimulus($urandom_range(0, 9) == 0, vw'($urandom), $urandom_range(0, 3) != 0,
                       vw'($urandom), $urandom_range(0, 15) == 0);
      end
      reset_n = 1'b1;
      idle(3);

      // Signed activations on the second instance.
      ifs.w_load = 1'b1; ifs.w_in = 16'h7777;
      @(posedge clk); #1;
      ifs.w_load = 1'b0; ifs.in_valid = 1'b1; ifs.a_in = 16'h8888; ifs.acc_clr = 1'b1;
      @(posedge clk); #1;
      ifs.in_valid = 1'b0; ifs.acc_clr = 1'b0;
      @(posedge clk); #1;
      checkOutput("signed_act_out", longint'($signed(ifs.out)), -224);
      checkOutput("signed_act_valid", longint'(ifs.out_valid), 1);
      checkOutput("signed_act_ovf", longint'(ifs.ovf), 0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_lane_acc.md
MAC_LANE_ACC -- requirements
Module: mac_lane_acc

Interface
REQ-001 Parameter bw, default 4, activation and weight width per lane.
REQ-002 Parameter psum_bw, default 16, accumulator and output width.
REQ-003 Parameter lanes, default 4, parallel activation/weight pairs summed per beat.
REQ-004 Parameter act_signed, default 0: 0 means activations are unsigned, 1 means two's complement.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 w_load  in  1  when high, capture w_in into the weight register.
REQ-008 w_in  in  lanes*bw  packed signed weights; lane k is at [k*bw +: bw].
REQ-009 in_valid  in  1  activation beat present.
REQ-010 a_in  in  lanes*bw  packed activations, same packing as w_in.
REQ-011 acc_clr  in  1  the next accumulation starts from zero.
REQ-012 out  out  psum_bw  current accumulator value, signed.
REQ-013 out_valid  out  1  one-cycle pulse when the accumulator has absorbed a beat.
REQ-014 ovf  out  1  sticky signed-overflow flag.

Function
REQ-015 Per lane: product = a*b, with b signed and a signedness set by act_signed; product width is 2*bw+1, then sign-extended to psum_bw.
REQ-016 Stage 1 (edge after in_valid): register the lane products and a valid bit. Weights are read from the weight register as it stood before that edge.
REQ-017 Stage 2 (next edge): the adder tree sums all lane products at psum_bw width, and acc <= acc + sum, wrapping two's complement.
REQ-018 Latency: in_valid at edge t gives an updated out and out_valid=1 at edge t+2; full throughput, one beat per cycle, no stalls.
REQ-019 w_load and in_valid on the same edge: that beat uses the old weights, and the new weights apply from the following beat.
REQ-020 acc_clr is registered alongside stage 1; at stage 2 with valid, acc <= sum (the old acc is discarded).
REQ-021 acc_clr at stage 2 without valid: acc <= 0, out_valid stays 0, and ovf is cleared.
REQ-022 Any accumulation that starts via acc_clr also clears ovf before evaluating that beat.
REQ-023 ovf is set when the stage-2 add overflows signed psum_bw (operands share a sign and the result sign differs); it stays set until acc_clr or reset.
REQ-024 out holds its value between beats; out_valid is 0 in every cycle without a stage-2 update.
REQ-025 Lane sum overflow inside the adder tree is impossible by width: lanes*2^(2*bw) must fit in psum_bw; an elaboration-time check rejects violating parameters.

Reset
REQ-026 reset_n=0 at an edge clears: weight register to 0, both pipeline valid bits to 0, acc/out to 0, out_valid to 0, ovf to 0.
REQ-027 Reset mid-operation drops all in-flight beats; no out_valid follows for beats accepted before reset.
REQ-028 Reset takes priority over w_load, in_valid and acc_clr on the same edge.

Structure
REQ-029 Shared package mac_pkg holds the default bw/psum_bw/lanes constants and the product-width function 2*bw+1.
REQ-030 One sub-module, mac_mul: a combinational single-lane multiplier with an act_signed parameter, instantiated lanes times.
REQ-031 Pipeline registers, the weight register and the accumulator live in mac_lane_acc only.

Verification
REQ-032 Setup: defaults, w_in lanes {1,2,3,4}, acc_clr with first beat, a_in all 1 for 3 beats. Expected: out_valid at t+2, t+3, t+4 with out = 10, 20, 30.
REQ-033 Setup: weights {-8,-8,-8,-8}, a_in all 15 (unsigned), acc_clr. Expected: out = -480; after 68 more beats ovf=1 and out has wrapped, with the exact value checked against the model.
REQ-034 Setup: act_signed=1, weights {7,7,7,7}, a_in {-8,-8,-8,-8}. Expected: out = -224.
REQ-035 Setup: w_load {2,2,2,2} and in_valid (a all 1) on the same edge, old weights all 1, then a second beat. Expected: first beat adds 4, second adds 8.
REQ-036 Setup: reset_n=0 for one edge one cycle after in_valid. Expected: no out_valid afterwards; out=0 and ovf=0.
REQ-037 Setup: acc_clr alone with no valid, acc=30, ovf=1. Expected: next out=0, ovf=0, out_valid=0.
